// File: rtl/mpu_regfile_arbiter.sv
// Round-robin burst arbiter sharing the matrix register-file write port between the
// load path (ld) and the multiply writeback path (wb), with a stall watchdog.
module mpu_regfile_arbiter #(
  parameter int unsigned TIMEOUT         = 16,
  parameter int unsigned FP              = 32,
  parameter int unsigned MBITS           = 3,
  parameter int unsigned NBITS           = 3,
  parameter int unsigned MATRIX_REG_SIZE = 4
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       ld_req_in,
  input  logic                       ld_valid_in,
  input  logic                       ld_last_in,
  input  logic [MATRIX_REG_SIZE-1:0] ld_addr_in,
  input  logic [FP-1:0]              ld_element_in,
  input  logic [MBITS:0]             ld_i_in,
  input  logic [NBITS:0]             ld_j_in,
  input  logic [MBITS:0]             ld_m_in,
  input  logic [NBITS:0]             ld_n_in,
  output logic                       ld_gnt_out,
  output logic                       ld_ready_out,

  input  logic                       wb_req_in,
  input  logic                       wb_valid_in,
  input  logic                       wb_last_in,
  input  logic [MATRIX_REG_SIZE-1:0] wb_addr_in,
  input  logic [FP-1:0]              wb_element_in,
  input  logic [MBITS:0]             wb_i_in,
  input  logic [NBITS:0]             wb_j_in,
  input  logic [MBITS:0]             wb_m_in,
  input  logic [NBITS:0]             wb_n_in,
  output logic                       wb_gnt_out,
  output logic                       wb_ready_out,

  input  logic                       reg_ready_in,
  output logic                       reg_load_en_out,
  output logic [MATRIX_REG_SIZE-1:0] reg_load_addr_out,
  output logic [FP-1:0]              reg_load_element_out,
  output logic [MBITS:0]             reg_i_load_loc_out,
  output logic [NBITS:0]             reg_j_load_loc_out,
  output logic [MBITS:0]             reg_m_load_size_out,
  output logic [NBITS:0]             reg_n_load_size_out,

  output logic                       arb_owner_out,
  output logic                       arb_timeout_out
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [0:0] {ArbIdle, ArbGrant} state_e;

  state_e        state_q;
  logic          owner_q;  // 0 = ld, 1 = wb
  logic          prio_q;   // side that wins the next contention
  logic [TW-1:0] timer_q;
  logic          ld_gnt_q, wb_gnt_q, timeout_q;

  logic granted, own_valid, own_last, own_req, beat, expire, done, win_wb;

  assign granted   = rst && (state_q == ArbGrant);
  assign own_valid = owner_q ? wb_valid_in : ld_valid_in;
  assign own_last  = owner_q ? wb_last_in  : ld_last_in;
  assign own_req   = owner_q ? wb_req_in   : ld_req_in;
  assign beat      = granted && own_valid && reg_ready_in;
  assign expire    = (timer_q == TW'(TIMEOUT - 1));
  // A beat at expiry takes precedence over both abort and timeout.
  assign done      = granted && (beat ? own_last : (!own_req || expire));
  assign win_wb    = wb_req_in && (!ld_req_in || prio_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ArbIdle;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      timer_q   <= '0;
      ld_gnt_q  <= 1'b0;
      wb_gnt_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        ArbIdle: begin
          if (ld_req_in || wb_req_in) begin
            state_q  <= ArbGrant;
            owner_q  <= win_wb;
            ld_gnt_q <= !win_wb;
            wb_gnt_q <= win_wb;
            timer_q  <= '0;
          end
        end
        ArbGrant: begin
          if (done) begin
            state_q   <= ArbIdle;
            prio_q    <= !owner_q;
            ld_gnt_q  <= 1'b0;
            wb_gnt_q  <= 1'b0;
            timer_q   <= '0;
            timeout_q <= !beat && own_req && expire;
          end else if (beat) begin
            timer_q <= '0;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

  assign ld_gnt_out      = ld_gnt_q;
  assign wb_gnt_out      = wb_gnt_q;
  assign arb_owner_out   = owner_q;
  assign arb_timeout_out = timeout_q;
  assign ld_ready_out    = granted && !owner_q && reg_ready_in;
  assign wb_ready_out    = granted && owner_q && reg_ready_in;
  assign reg_load_en_out = beat;

  always_comb begin
    reg_load_addr_out    = '0;
    reg_load_element_out = '0;
    reg_i_load_loc_out   = '0;
    reg_j_load_loc_out   = '0;
    reg_m_load_size_out  = '0;
    reg_n_load_size_out  = '0;
    if (beat) begin
      if (owner_q) begin
        reg_load_addr_out    = wb_addr_in;
        reg_load_element_out = wb_element_in;
        reg_i_load_loc_out   = wb_i_in;
        reg_j_load_loc_out   = wb_j_in;
        reg_m_load_size_out  = wb_m_in;
        reg_n_load_size_out  = wb_n_in;
      end else begin
        reg_load_addr_out    = ld_addr_in;
        reg_load_element_out = ld_element_in;
        reg_i_load_loc_out   = ld_i_in;
        reg_j_load_loc_out   = ld_j_in;
        reg_m_load_size_out  = ld_m_in;
        reg_n_load_size_out  = ld_n_in;
      end
    end
  end

endmodule

// File: tb/tb_mpu_regfile_arbiter.sv
// Directed bench for mpu_regfile_arbiter: a per-cycle vector table for bursts, reset and
// contention, then hand sequences for backpressure, watchdog timeout and abort.
module tb_mpu_regfile_arbiter;

  logic        clk;
  logic        rst;
  logic        ld_req, ld_valid, ld_last, ld_gnt, ld_ready;
  logic [3:0]  ld_addr, ld_i, ld_j, ld_m, ld_n;
  logic [31:0] ld_elem;
  logic        wb_req, wb_valid, wb_last, wb_gnt, wb_ready;
  logic [3:0]  wb_addr, wb_i, wb_j, wb_m, wb_n;
  logic [31:0] wb_elem;
  logic        reg_ready, reg_en, owner, tout;
  logic [3:0]  r_addr, r_i, r_j, r_m, r_n;
  logic [31:0] r_elem;

  int n_tests = 0;
  int n_fail  = 0;

  mpu_regfile_arbiter dut (
    .clk                  (clk),
    .rst                  (rst),
    .ld_req_in            (ld_req),
    .ld_valid_in          (ld_valid),
    .ld_last_in           (ld_last),
    .ld_addr_in           (ld_addr),
    .ld_element_in        (ld_elem),
    .ld_i_in              (ld_i),
    .ld_j_in              (ld_j),
    .ld_m_in              (ld_m),
    .ld_n_in              (ld_n),
    .ld_gnt_out           (ld_gnt),
    .ld_ready_out         (ld_ready),
    .wb_req_in            (wb_req),
    .wb_valid_in          (wb_valid),
    .wb_last_in           (wb_last),
    .wb_addr_in           (wb_addr),
    .wb_element_in        (wb_elem),
    .wb_i_in              (wb_i),
    .wb_j_in              (wb_j),
    .wb_m_in              (wb_m),
    .wb_n_in              (wb_n),
    .wb_gnt_out           (wb_gnt),
    .wb_ready_out         (wb_ready),
    .reg_ready_in         (reg_ready),
    .reg_load_en_out      (reg_en),
    .reg_load_addr_out    (r_addr),
    .reg_load_element_out (r_elem),
    .reg_i_load_loc_out   (r_i),
    .reg_j_load_loc_out   (r_j),
    .reg_m_load_size_out  (r_m),
    .reg_n_load_size_out  (r_n),
    .arb_owner_out        (owner),
    .arb_timeout_out      (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
    $fatal(1);
  end

  typedef struct {
    logic       rst, rr;
    logic       lr, lv, ll;
    logic [3:0] li, lj;
    logic       wr, wv, wl;
    logic [3:0] wi, wj;
    logic       e_lg, e_wg, e_lrdy, e_wrdy, e_en, e_own;
    logic [3:0] e_i, e_j;
  } vec_t;

  function automatic vec_t mk(input logic r, rr, lr, lv, ll, input logic [3:0] li, lj,
                              input logic wr, wv, wl, input logic [3:0] wi, wj,
                              input logic lg, wg, lrdy, wrdy, en, own,
                              input logic [3:0] ei, ej);
    vec_t v;
    v.rst = r;  v.rr = rr;
    v.lr = lr;  v.lv = lv;  v.ll = ll;  v.li = li;  v.lj = lj;
    v.wr = wr;  v.wv = wv;  v.wl = wl;  v.wi = wi;  v.wj = wj;
    v.e_lg = lg;  v.e_wg = wg;  v.e_lrdy = lrdy;  v.e_wrdy = wrdy;
    v.e_en = en;  v.e_own = own;  v.e_i = ei;  v.e_j = ej;
    return v;
  endfunction

  function automatic logic [31:0] elem_of(input logic wb, input logic [3:0] i, j);
    return {(wb ? 16'hB0B0 : 16'hA0A0), 4'h0, i, 4'h0, j};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_ld(input logic req, valid, last, input logic [3:0] i, j);
    ld_req = req;  ld_valid = valid;  ld_last = last;  ld_i = i;  ld_j = j;
    ld_addr = 4'h3;  ld_m = 4'd2;  ld_n = 4'd2;  ld_elem = elem_of(1'b0, i, j);
  endtask

  task automatic set_wb(input logic req, valid, last, input logic [3:0] i, j);
    wb_req = req;  wb_valid = valid;  wb_last = last;  wb_i = i;  wb_j = j;
    wb_addr = 4'h9;  wb_m = 4'd3;  wb_n = 4'd1;  wb_elem = elem_of(1'b1, i, j);
  endtask

  // Check mid-cycle, then advance to just after the next posedge.
  task automatic cyc(input string nm, input logic lg, wg, lrdy, wrdy, en, to,
                     input logic [3:0] j);
    #4;
    chk({nm, ".ld_gnt"}, ld_gnt, lg);
    chk({nm, ".wb_gnt"}, wb_gnt, wg);
    chk({nm, ".ld_ready"}, ld_ready, lrdy);
    chk({nm, ".wb_ready"}, wb_ready, wrdy);
    chk({nm, ".en"}, reg_en, en);
    chk({nm, ".timeout"}, tout, to);
    chk({nm, ".j"}, r_j, j);
    @(posedge clk);
    #1;
  endtask

  vec_t vt[$];

  initial begin
    // T2 single ld 2x2 burst
    vt.push_back(mk(1,1, 1,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,1, 1,1,0,0,0, 0,0,0,0,0, 1,0,1,0,1,0,0,0));
    vt.push_back(mk(1,1, 1,1,0,0,1, 0,0,0,0,0, 1,0,1,0,1,0,0,1));
    vt.push_back(mk(1,1, 1,1,0,1,0, 0,0,0,0,0, 1,0,1,0,1,0,1,0));
    vt.push_back(mk(1,1, 1,1,1,1,1, 0,0,0,0,0, 1,0,1,0,1,0,1,1));
    vt.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0));
    // T1 reset held 3 cycles mid-burst
    vt.push_back(mk(1,1, 1,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,1, 1,1,0,0,0, 0,0,0,0,0, 1,0,1,0,1,0,0,0));
    vt.push_back(mk(0,1, 1,1,0,0,1, 0,0,0,0,0, 1,0,0,0,0,0,0,0));
    vt.push_back(mk(0,1, 1,1,0,0,1, 1,1,0,7,7, 0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,1, 1,1,0,0,1, 1,1,0,7,7, 0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,1, 1,0,0,0,0, 1,0,0,7,7, 0,0,0,0,0,0,0,0));
    // T3 contention: ld first after reset, then wb wins the next contention
    vt.push_back(mk(1,1, 1,1,0,0,0, 1,1,0,7,7, 1,0,1,0,1,0,0,0));
    vt.push_back(mk(1,1, 1,1,0,0,1, 1,1,0,7,7, 1,0,1,0,1,0,0,1));
    vt.push_back(mk(1,1, 1,1,1,0,2, 1,1,0,7,7, 1,0,1,0,1,0,0,2));
    vt.push_back(mk(1,1, 1,0,0,0,0, 1,0,0,0,0, 0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,1, 1,1,0,5,5, 1,1,0,0,0, 0,1,0,1,1,1,0,0));
    vt.push_back(mk(1,1, 1,1,0,5,5, 1,1,0,1,0, 0,1,0,1,1,1,1,0));
    vt.push_back(mk(1,1, 1,1,0,5,5, 1,1,1,2,0, 0,1,0,1,1,1,2,0));
    vt.push_back(mk(1,1, 1,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,1, 1,1,1,2,2, 0,0,0,0,0, 1,0,1,0,1,0,2,2));
    vt.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0));

    rst = 1'b0;
    reg_ready = 1'b1;
    set_ld(0, 0, 0, 0, 0);
    set_wb(0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;

    foreach (vt[k]) begin
      vec_t v;
      logic [31:0] e_elem;
      v = vt[k];
      rst = v.rst;
      reg_ready = v.rr;
      set_ld(v.lr, v.lv, v.ll, v.li, v.lj);
      set_wb(v.wr, v.wv, v.wl, v.wi, v.wj);
      e_elem = v.e_en ? elem_of(v.e_own, v.e_i, v.e_j) : 32'h0;
      #4;
      chk($sformatf("v%0d.ld_gnt", k), ld_gnt, v.e_lg);
      chk($sformatf("v%0d.wb_gnt", k), wb_gnt, v.e_wg);
      chk($sformatf("v%0d.ld_ready", k), ld_ready, v.e_lrdy);
      chk($sformatf("v%0d.wb_ready", k), wb_ready, v.e_wrdy);
      chk($sformatf("v%0d.en", k), reg_en, v.e_en);
      chk($sformatf("v%0d.timeout", k), tout, 1'b0);
      chk($sformatf("v%0d.i", k), r_i, v.e_i);
      chk($sformatf("v%0d.j", k), r_j, v.e_j);
      chk($sformatf("v%0d.elem", k), r_elem, e_elem);
      chk($sformatf("v%0d.addr", k), r_addr, v.e_en ? (v.e_own ? 4'h9 : 4'h3) : 4'h0);
      chk($sformatf("v%0d.m", k), r_m, v.e_en ? (v.e_own ? 4'd3 : 4'd2) : 4'd0);
      chk($sformatf("v%0d.n", k), r_n, v.e_en ? (v.e_own ? 4'd1 : 4'd2) : 4'd0);
      if (v.e_lg || v.e_wg || !v.rst) chk($sformatf("v%0d.owner", k), owner, v.e_own);
      @(posedge clk);
      #1;
    end

    // T4 backpressure: prio is wb, but only ld requests
    rst = 1'b1;
    reg_ready = 1'b1;
    set_wb(0, 0, 0, 0, 0);
    set_ld(1, 0, 0, 0, 0);  cyc("t4.idle", 0,0,0,0,0,0, 0);
    set_ld(1, 1, 0, 0, 0);  cyc("t4.b0",   1,0,1,0,1,0, 0);
    reg_ready = 1'b0;
    set_ld(1, 1, 0, 0, 1);
    for (int n = 0; n < 5; n++) cyc($sformatf("t4.stall%0d", n), 1,0,0,0,0,0, 0);
    reg_ready = 1'b1;
    cyc("t4.b1", 1,0,1,0,1,0, 1);
    set_ld(1, 1, 0, 1, 0);  cyc("t4.b2",   1,0,1,0,1,0, 0);
    set_ld(1, 1, 1, 1, 1);  cyc("t4.b3",   1,0,1,0,1,0, 1);
    set_ld(0, 0, 0, 0, 0);  cyc("t4.done", 0,0,0,0,0,0, 0);

    // T5 watchdog: wb wins (prio wb), never sends a beat
    set_wb(1, 0, 0, 0, 0);
    set_ld(1, 0, 0, 0, 0);  cyc("t5.idle", 0,0,0,0,0,0, 0);
    for (int n = 0; n < 16; n++) cyc($sformatf("t5.wait%0d", n), 0,1,0,1,0,0, 0);
    cyc("t5.pulse", 0,0,0,0,0,1, 0);
    set_ld(1, 1, 1, 2, 3);  cyc("t5.ld",   1,0,1,0,1,0, 3);
    set_wb(0, 0, 0, 0, 0);
    set_ld(0, 0, 0, 0, 0);  cyc("t5.done", 0,0,0,0,0,0, 0);

    // T6 abort after 2 of 4 beats, then a beat exactly at watchdog expiry
    set_ld(1, 0, 0, 0, 0);  cyc("t6.idle", 0,0,0,0,0,0, 0);
    set_wb(1, 0, 0, 0, 0);
    set_ld(1, 1, 0, 0, 0);  cyc("t6.b0",   1,0,1,0,1,0, 0);
    set_ld(1, 1, 0, 0, 1);  cyc("t6.b1",   1,0,1,0,1,0, 1);
    set_ld(0, 0, 0, 0, 0);  cyc("t6.drop", 1,0,1,0,0,0, 0);
    cyc("t6.abort", 0,0,0,0,0,0, 0);
    for (int n = 0; n < 15; n++) cyc($sformatf("t6.wbwait%0d", n), 0,1,0,1,0,0, 0);
    set_wb(1, 1, 0, 0, 5);  cyc("t6.edge", 0,1,0,1,1,0, 5);
    set_wb(1, 0, 0, 0, 0);  cyc("t6.kept", 0,1,0,1,0,0, 0);
    set_wb(1, 1, 1, 0, 6);  cyc("t6.last", 0,1,0,1,1,0, 6);
    set_wb(0, 0, 0, 0, 0);  cyc("t6.done", 0,0,0,0,0,0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
